// File: rtl/apb4_types_pkg.sv
// Shared types and sizing helpers for the APB4 multi-slave requester and its address decoder.
package apb4_types_pkg;

   typedef enum logic {
      APB_OP_READ_E  = 1'b0,
      APB_OP_WRITE_E = 1'b1
   } apb_op_t;

   typedef enum logic [1:0] {
      APB_OK_E      = 2'd0,
      APB_SLVERR_E  = 2'd1,
      APB_DECERR_E  = 2'd2,
      APB_TIMEOUT_E = 2'd3
   } apb_status_t;

   typedef enum logic [1:0] {
      APB_IDLE_E   = 2'd0,
      APB_SETUP_E  = 2'd1,
      APB_ACCESS_E = 2'd2,
      APB_RESP_E   = 2'd3
   } apb_fsm_t;

   typedef struct packed {
      logic [31:0] addr_width;
      logic [31:0] data_width;
      logic [31:0] nr_of_slaves;
      logic [31:0] sel_lsb;
      logic [31:0] timeout_cycles;
   } apb4_cfg_t;

   // Slave-index field width; never narrower than one bit.
   function automatic int unsigned apb_idx_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

   // Timeout counter width; one bit is kept even when the timeout is disabled.
   function automatic int unsigned apb_cnt_width(input int unsigned t);
      return (t > 0) ? int'($clog2(t + 1)) : 1;
   endfunction

endpackage

// File: rtl/apb4_addr_decoder.sv
// Combinational slave decode: address bits from the select field upward to
// {slave index, one-hot select, decode error}.
module apb4_addr_decoder
   import apb4_types_pkg::*;
#(
   parameter int unsigned HI_WIDTH_P     = 20,
   parameter int unsigned NR_OF_SLAVES_P = 4,
   localparam int unsigned IDX_W         = apb_idx_width(NR_OF_SLAVES_P)
) (
   input  logic [HI_WIDTH_P-1:0]     addr_hi,
   output logic [IDX_W-1:0]          idx,
   output logic [NR_OF_SLAVES_P-1:0] sel,
   output logic                      decerr
);

   localparam int unsigned IDX_W1 = IDX_W + 1;
   localparam logic [IDX_W1-1:0] NR_L = IDX_W1'(NR_OF_SLAVES_P);

   logic upper_nz;

   assign idx = addr_hi[IDX_W-1:0];

   // Any set bit above the index field lies outside every slave window.
   if (HI_WIDTH_P > IDX_W) begin : g_upper
      assign upper_nz = |addr_hi[HI_WIDTH_P-1:IDX_W];
   end else begin : g_no_upper
      assign upper_nz = 1'b0;
   end

   assign decerr = upper_nz || ({1'b0, idx} >= NR_L);
   assign sel    = decerr ? '0 : (NR_OF_SLAVES_P'(1) << idx);

endmodule

// File: rtl/apb4_multi_slave_master.sv
// APB4 requester: valid/ready command in, one APB4 transfer to a decoded slave,
// status-coded response out. All outputs are registered.
module apb4_multi_slave_master
   import apb4_types_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH_P   = 32,
   parameter int unsigned APB_DATA_WIDTH_P   = 32,
   parameter int unsigned APB_NR_OF_SLAVES_P = 4,
   parameter int unsigned SLAVE_SEL_LSB_P    = 12,
   parameter int unsigned TIMEOUT_CYCLES_P   = 256
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          cmd_valid,
   output logic                                          cmd_ready,
   input  logic                                          cmd_write,
   input  logic [APB_ADDR_WIDTH_P-1:0]                   cmd_addr,
   input  logic [APB_DATA_WIDTH_P-1:0]                   cmd_wdata,
   input  logic [APB_DATA_WIDTH_P/8-1:0]                 cmd_wstrb,
   input  logic [2:0]                                    cmd_prot,
   output logic                                          rsp_valid,
   input  logic                                          rsp_ready,
   output logic [APB_DATA_WIDTH_P-1:0]                   rsp_rdata,
   output logic [1:0]                                    rsp_status,
   output logic [APB_ADDR_WIDTH_P-1:0]                   apb_paddr,
   output logic [APB_NR_OF_SLAVES_P-1:0]                 apb_psel,
   output logic                                          apb_penable,
   output logic                                          apb_pwrite,
   output logic [APB_DATA_WIDTH_P-1:0]                   apb_pwdata,
   output logic [APB_DATA_WIDTH_P/8-1:0]                 apb_pstrb,
   output logic [2:0]                                    apb_pprot,
   input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] apb_prdata,
   input  logic [APB_NR_OF_SLAVES_P-1:0]                 apb_pready,
   input  logic [APB_NR_OF_SLAVES_P-1:0]                 apb_pslverr
);

   localparam int unsigned AW    = APB_ADDR_WIDTH_P;
   localparam int unsigned DW    = APB_DATA_WIDTH_P;
   localparam int unsigned SW    = APB_DATA_WIDTH_P / 8;
   localparam int unsigned N     = APB_NR_OF_SLAVES_P;
   localparam int unsigned HI_W  = AW - SLAVE_SEL_LSB_P;
   localparam int unsigned IDX_W = apb_idx_width(N);
   localparam int unsigned TO_W  = apb_cnt_width(TIMEOUT_CYCLES_P);
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES_P > 0) ? TIMEOUT_CYCLES_P - 1 : 0);

   apb_fsm_t           state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TO_W-1:0]    tcnt_q, tcnt_d;

   logic               cmd_ready_d;
   logic               rsp_valid_d;
   logic [DW-1:0]      rsp_rdata_d;
   apb_status_t        rsp_status_d;
   logic [AW-1:0]      paddr_d;
   logic [N-1:0]       psel_d;
   logic               penable_d;
   logic               pwrite_d;
   logic [DW-1:0]      pwdata_d;
   logic [SW-1:0]      pstrb_d;
   logic [2:0]         pprot_d;

   logic [IDX_W-1:0]   dec_idx;
   logic [N-1:0]       dec_sel;
   logic               dec_err;

   logic               sel_ready;
   logic               sel_slverr;
   logic [DW-1:0]      sel_rdata;
   logic               timeout_hit;
   apb_op_t            op;

   apb4_addr_decoder #(
      .HI_WIDTH_P     (HI_W),
      .NR_OF_SLAVES_P (N)
   ) u_addr_decoder (
      .addr_hi (cmd_addr[AW-1:SLAVE_SEL_LSB_P]),
      .idx     (dec_idx),
      .sel     (dec_sel),
      .decerr  (dec_err)
   );

   // Response signals of the addressed slave only; others are ignored.
   always_comb begin
      sel_ready  = 1'b0;
      sel_slverr = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ready  = apb_pready[i];
            sel_slverr = apb_pslverr[i];
            sel_rdata  = apb_prdata[i*DW +: DW];
         end
      end
   end

   assign timeout_hit = (TIMEOUT_CYCLES_P != 0) && (tcnt_q == TO_LAST);
   assign op          = apb_op_t'(cmd_write);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tcnt_d       = tcnt_q;
      cmd_ready_d  = cmd_ready;
      rsp_valid_d  = rsp_valid;
      rsp_rdata_d  = rsp_rdata;
      rsp_status_d = apb_status_t'(rsp_status);
      paddr_d      = apb_paddr;
      psel_d       = apb_psel;
      penable_d    = apb_penable;
      pwrite_d     = apb_pwrite;
      pwdata_d     = apb_pwdata;
      pstrb_d      = apb_pstrb;
      pprot_d      = apb_pprot;

      case (state_q)
         APB_IDLE_E: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid) begin
               cmd_ready_d = 1'b0;
               tcnt_d      = '0;
               idx_d       = dec_idx;
               paddr_d     = cmd_addr;
               pwrite_d    = (op == APB_OP_WRITE_E);
               pwdata_d    = cmd_wdata;
               pstrb_d     = (op == APB_OP_WRITE_E) ? cmd_wstrb : '0;
               pprot_d     = cmd_prot;
               if (dec_err) begin
                  state_d      = APB_RESP_E;
                  rsp_valid_d  = 1'b1;
                  rsp_rdata_d  = '0;
                  rsp_status_d = APB_DECERR_E;
               end else begin
                  state_d = APB_SETUP_E;
                  psel_d  = dec_sel;
               end
            end
         end

         APB_SETUP_E: begin
            penable_d = 1'b1;
            state_d   = APB_ACCESS_E;
         end

         APB_ACCESS_E: begin
            // A PREADY in the final allowed cycle beats the timeout.
            if (sel_ready) begin
               state_d      = APB_RESP_E;
               psel_d       = '0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = apb_pwrite ? '0 : sel_rdata;
               rsp_status_d = sel_slverr ? APB_SLVERR_E : APB_OK_E;
            end else if (timeout_hit) begin
               state_d      = APB_RESP_E;
               psel_d       = '0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = '0;
               rsp_status_d = APB_TIMEOUT_E;
            end else if (TIMEOUT_CYCLES_P != 0) begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end

         APB_RESP_E: begin
            if (rsp_ready) begin
               state_d     = APB_IDLE_E;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               tcnt_d      = '0;
            end
         end

         default: begin
            state_d = APB_IDLE_E;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= APB_IDLE_E;
         idx_q       <= '0;
         tcnt_q      <= '0;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_status  <= 2'b00;
         apb_paddr   <= '0;
         apb_psel    <= '0;
         apb_penable <= 1'b0;
         apb_pwrite  <= 1'b0;
         apb_pwdata  <= '0;
         apb_pstrb   <= '0;
         apb_pprot   <= 3'b000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tcnt_q      <= tcnt_d;
         cmd_ready   <= cmd_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_status  <= rsp_status_d;
         apb_paddr   <= paddr_d;
         apb_psel    <= psel_d;
         apb_penable <= penable_d;
         apb_pwrite  <= pwrite_d;
         apb_pwdata  <= pwdata_d;
         apb_pstrb   <= pstrb_d;
         apb_pprot   <= pprot_d;
      end
   end

endmodule

// File: tb/tb_apb4_multi_slave_master.sv
// Directed bench for apb4_multi_slave_master with hand-computed expectations.
module tb_apb4_multi_slave_master;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned N   = 4;
   localparam int unsigned LSB = 12;
   localparam int unsigned TO  = 8;
   localparam int unsigned SW  = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AW-1:0]     cmd_addr;
   logic [DW-1:0]     cmd_wdata;
   logic [SW-1:0]     cmd_wstrb;
   logic [2:0]        cmd_prot;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_status;
   logic [AW-1:0]     apb_paddr;
   logic [N-1:0]      apb_psel;
   logic              apb_penable;
   logic              apb_pwrite;
   logic [DW-1:0]     apb_pwdata;
   logic [SW-1:0]     apb_pstrb;
   logic [2:0]        apb_pprot;
   logic [N*DW-1:0]   apb_prdata;
   logic [N-1:0]      apb_pready;
   logic [N-1:0]      apb_pslverr;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   apb4_multi_slave_master #(
      .APB_ADDR_WIDTH_P   (AW),
      .APB_DATA_WIDTH_P   (DW),
      .APB_NR_OF_SLAVES_P (N),
      .SLAVE_SEL_LSB_P    (LSB),
      .TIMEOUT_CYCLES_P   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_status  (rsp_status),
      .apb_paddr   (apb_paddr),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_pwdata  (apb_pwdata),
      .apb_pstrb   (apb_pstrb),
      .apb_pprot   (apb_pprot),
      .apb_prdata  (apb_prdata),
      .apb_pready  (apb_pready),
      .apb_pslverr (apb_pslverr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled and inputs driven 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command for one cycle (the accept cycle) and returns in the SETUP cycle.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] strb, input logic [2:0] prot);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wstrb = strb;
      cmd_prot  = prot;
      check_eq("cmd_ready_at_accept", 64'(cmd_ready), 64'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq({tag, "_rsp_drop"}, 64'(rsp_valid), 64'(0));
      check_eq({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'(1));
   endtask

   task automatic set_rdata(input int idx, input logic [DW-1:0] v);
      apb_prdata[idx*DW +: DW] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic strb_bad;

      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      cmd_wstrb   = '0;
      cmd_prot    = '0;
      rsp_ready   = 1'b0;
      apb_prdata  = '0;
      apb_pready  = '0;
      apb_pslverr = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_psel", 64'(apb_psel), 64'(0));
      check_eq("rst_penable", 64'(apb_penable), 64'(0));
      check_eq("rst_status", 64'(rsp_status), 64'(0));
      check_eq("rst_paddr", 64'(apb_paddr), 64'(0));

      // Zero-wait write to slave 1
      apb_pready = 4'b0010;
      issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
      check_eq("wr_setup_psel", 64'(apb_psel), 64'(4'b0010));
      check_eq("wr_setup_penable", 64'(apb_penable), 64'(0));
      check_eq("wr_setup_paddr", 64'(apb_paddr), 64'(32'h0000_1004));
      check_eq("wr_setup_pwrite", 64'(apb_pwrite), 64'(1));
      check_eq("wr_setup_pwdata", 64'(apb_pwdata), 64'(32'hDEAD_BEEF));
      check_eq("wr_setup_pstrb", 64'(apb_pstrb), 64'(4'hF));
      check_eq("wr_setup_pprot", 64'(apb_pprot), 64'(3'b010));
      check_eq("wr_setup_cmd_ready", 64'(cmd_ready), 64'(0));
      tick();
      check_eq("wr_access_penable", 64'(apb_penable), 64'(1));
      check_eq("wr_access_psel", 64'(apb_psel), 64'(4'b0010));
      check_eq("wr_access_rsp_valid", 64'(rsp_valid), 64'(0));
      tick();
      check_eq("wr_resp_valid", 64'(rsp_valid), 64'(1));
      check_eq("wr_resp_status", 64'(rsp_status), 64'(0));
      check_eq("wr_resp_rdata", 64'(rsp_rdata), 64'(0));
      check_eq("wr_resp_psel", 64'(apb_psel), 64'(0));
      check_eq("wr_resp_penable", 64'(apb_penable), 64'(0));
      apb_pready = '0;
      finish_rsp("wr");

      // Read from slave 3 with 5 wait states; other slaves answer and must be ignored
      set_rdata(3, 32'h1234_5678);
      set_rdata(1, 32'hAAAA_AAAA);
      issue(1'b0, 32'h0000_3010, 32'h5555_5555, 4'hF, 3'b000);
      n = 0;
      strb_bad = 1'b0;
      while (apb_psel == 4'b1000 && n < 20) begin
         n++;
         if (apb_pstrb != 4'h0) strb_bad = 1'b1;
         apb_pready  = (n == 7) ? 4'b1000 : 4'b0111;
         apb_pslverr = 4'b0111;
         tick();
      end
      apb_pready  = '0;
      apb_pslverr = '0;
      check_eq("rd_psel_cycles", 64'(n), 64'(7));
      check_eq("rd_pstrb_zero", 64'(strb_bad), 64'(0));
      check_eq("rd_rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("rd_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
      check_eq("rd_status", 64'(rsp_status), 64'(0));
      finish_rsp("rd");

      // Decode error: address bit above the index field
      issue(1'b0, 32'h0001_0000, 32'h0, 4'h0, 3'b000);
      check_eq("dec_rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("dec_status", 64'(rsp_status), 64'(2));
      check_eq("dec_rdata", 64'(rsp_rdata), 64'(0));
      check_eq("dec_psel", 64'(apb_psel), 64'(0));
      check_eq("dec_cmd_ready", 64'(cmd_ready), 64'(0));
      finish_rsp("dec");

      // Slave error on slave 2; a waiting command is held off until rsp_ready
      apb_pready  = 4'b0100;
      apb_pslverr = 4'b0100;
      issue(1'b1, 32'h0000_2000, 32'h0000_00FF, 4'h1, 3'b001);
      check_eq("err_setup_psel", 64'(apb_psel), 64'(4'b0100));
      tick();
      tick();
      apb_pready  = 4'b0001;
      apb_pslverr = '0;
      set_rdata(0, 32'hCAFE_F00D);
      check_eq("err_status", 64'(rsp_status), 64'(1));
      check_eq("err_rsp_valid", 64'(rsp_valid), 64'(1));
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0008;
      cmd_wstrb = 4'hF;
      tick();
      check_eq("err_hold_valid", 64'(rsp_valid), 64'(1));
      check_eq("err_hold_cmd_ready", 64'(cmd_ready), 64'(0));
      check_eq("err_hold_status", 64'(rsp_status), 64'(1));
      tick();
      check_eq("err_hold2_psel", 64'(apb_psel), 64'(0));
      check_eq("err_hold2_valid", 64'(rsp_valid), 64'(1));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq("err_idle_valid", 64'(rsp_valid), 64'(0));
      check_eq("err_idle_cmd_ready", 64'(cmd_ready), 64'(1));
      check_eq("err_idle_psel", 64'(apb_psel), 64'(0));
      tick();
      cmd_valid = 1'b0;
      check_eq("next_setup_psel", 64'(apb_psel), 64'(4'b0001));
      check_eq("next_setup_pstrb", 64'(apb_pstrb), 64'(0));
      tick();
      tick();
      check_eq("next_rdata", 64'(rsp_rdata), 64'(32'hCAFE_F00D));
      check_eq("next_status", 64'(rsp_status), 64'(0));
      apb_pready = '0;
      finish_rsp("next");

      // Timeout: slave 0 never ready
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000);
      tick();
      n = 0;
      while (apb_penable && n < 20) begin
         n++;
         tick();
      end
      check_eq("to_access_cycles", 64'(n), 64'(8));
      check_eq("to_psel", 64'(apb_psel), 64'(0));
      check_eq("to_rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("to_status", 64'(rsp_status), 64'(3));
      check_eq("to_rdata", 64'(rsp_rdata), 64'(0));
      finish_rsp("to");

      // PREADY in the 8th ACCESS cycle wins over the timeout
      issue(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000);
      tick();
      n = 0;
      while (apb_penable && n < 20) begin
         n++;
         apb_pready = (n == 8) ? 4'b0001 : 4'b0000;
         tick();
      end
      apb_pready = '0;
      check_eq("to_edge_cycles", 64'(n), 64'(8));
      check_eq("to_edge_status", 64'(rsp_status), 64'(0));
      check_eq("to_edge_rdata", 64'(rsp_rdata), 64'(32'hCAFE_F00D));
      finish_rsp("to_edge");

      // Reset asserted during ACCESS aborts the transfer
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
      tick();
      check_eq("rstacc_penable", 64'(apb_penable), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstacc_psel", 64'(apb_psel), 64'(0));
      check_eq("rstacc_penable_low", 64'(apb_penable), 64'(0));
      check_eq("rstacc_cmd_ready", 64'(cmd_ready), 64'(1));
      check_eq("rstacc_rsp_valid", 64'(rsp_valid), 64'(0));
      apb_pready = 4'b0010;
      set_rdata(1, 32'h0BAD_CAFE);
      issue(1'b0, 32'h0000_1008, 32'h0, 4'hF, 3'b000);
      check_eq("post_rst_psel", 64'(apb_psel), 64'(4'b0010));
      tick();
      tick();
      check_eq("post_rst_valid", 64'(rsp_valid), 64'(1));
      check_eq("post_rst_status", 64'(rsp_status), 64'(0));
      check_eq("post_rst_rdata", 64'(rsp_rdata), 64'(32'h0BAD_CAFE));
      apb_pready = '0;
      finish_rsp("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb4_multi_slave_master.md
Name: apb4_multi_slave_master

Overview:
- Parametrised APB4 requester. Converts a valid/ready command stream into APB4 transfers towards up to APB_NR_OF_SLAVES_P completers.
- Decodes the slave index from the address, drives PSTRB and PPROT, and returns a status-coded response on a valid/ready channel.
- Adds behaviour the APB3 generation lacks: byte strobes, protection bits, decode-error and PREADY-timeout detection.
- Sits between register-bus fabric (or a VIP sequencer-driven DUT harness) and peripheral register blocks.

Parameters:
- APB_ADDR_WIDTH_P, 32, address width.
- APB_DATA_WIDTH_P, 32, data width; must be a multiple of 8.
- APB_NR_OF_SLAVES_P, 4, number of PSEL lines; valid range 1..16.
- SLAVE_SEL_LSB_P, 12, LSB of the slave-index field in the address.
- TIMEOUT_CYCLES_P, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  APB_ADDR_WIDTH_P  byte address
- cmd_wdata  in  APB_DATA_WIDTH_P  write data
- cmd_wstrb  in  APB_DATA_WIDTH_P/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_rdata  out  APB_DATA_WIDTH_P  read data
- rsp_status  out  2  apb_status_t code
- apb_paddr  out  APB_ADDR_WIDTH_P  PADDR
- apb_psel  out  APB_NR_OF_SLAVES_P  one-hot PSEL
- apb_penable  out  1  PENABLE
- apb_pwrite  out  1  PWRITE
- apb_pwdata  out  APB_DATA_WIDTH_P  PWDATA
- apb_pstrb  out  APB_DATA_WIDTH_P/8  PSTRB
- apb_pprot  out  3  PPROT
- apb_prdata  in  APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P  flattened per-slave PRDATA, slave i at bits [i*DW +: DW]
- apb_pready  in  APB_NR_OF_SLAVES_P  per-slave PREADY
- apb_pslverr  in  APB_NR_OF_SLAVES_P  per-slave PSLVERR

Clock and reset: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset: all outputs are 0, except cmd_ready=1. FSM enters IDLE and the timeout counter clears. Reset asserted mid-transfer aborts the transfer: PSEL and PENABLE drop on the next edge and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, wdata, write, prot and strobe. Latched strobe = cmd_wstrb for writes; forced to 0 for reads.
  - Slave index = cmd_addr[SLAVE_SEL_LSB_P +: $clog2(N)], minimum 1 bit.
  - Decode error if the index is >= N, or any address bit above the index field is non-zero. On decode error go to RESP with status DECERR, rdata 0; no PSEL is asserted.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel[idx]=1, penable=0. paddr, pwrite, pwdata, pstrb and pprot are valid. Next state ACCESS.
- ACCESS:
  - penable=1, psel held; all other APB outputs stay stable.
  - Each cycle with pready[idx]=0 increments the timeout counter.
  - On pready[idx]=1: capture prdata slice idx (reads only; writes return 0). Status = SLVERR if pslverr[idx], else OK. Drop psel and penable, go to RESP.
  - pready and pslverr from unselected slaves are ignored.
  - Timeout: if TIMEOUT_CYCLES_P>0 and the counter reaches TIMEOUT_CYCLES_P-1 with pready low, abort. psel and penable drop, status TIMEOUT, rdata 0. A pready arriving in that same cycle takes priority, so the transfer completes normally.
- RESP: rsp_valid=1, with rdata and status held stable until rsp_ready. On handshake go to IDLE and clear the counter. cmd_ready=0 in SETUP, ACCESS and RESP.
- Latency: command accepted in cycle 0, SETUP in cycle 1, ACCESS from cycle 2. With zero wait states rsp_valid is asserted in cycle 3. Minimum 4 cycles per transfer when rsp_ready is held high.
- After a transfer, paddr, pwdata, pwrite, pstrb and pprot hold their last values; they are only meaningful while psel is asserted.

Decomposition:
- Shared package apb4_types_pkg contains:
  - apb_op_t (APB_OP_READ_E, APB_OP_WRITE_E)
  - apb_status_t, 2-bit: APB_OK_E=0, APB_SLVERR_E=1, APB_DECERR_E=2, APB_TIMEOUT_E=3
  - apb_fsm_t
  - apb4_cfg_t: addr width, data width, number of slaves, select LSB, timeout
- One sub-module, apb4_addr_decoder: combinational address to {index, one-hot select, decerr}. Reusable by the VIP scoreboard.

Test Plan:
- Write 0x0000_1004, wdata 0xDEADBEEF, wstrb 0xF, prot 3'b010; slave 1 holds pready high -> psel=4'b0010, penable in cycle 2, pstrb=0xF, rsp_valid in cycle 3, status OK.
- Read 0x0000_3010; slave 3 inserts 5 wait states, then prdata=0x1234_5678 -> rdata=0x1234_5678, pstrb=0 throughout, psel stable for 7 cycles.
- Read 0x0001_0000 with N=4 (upper bit set) -> no PSEL, rsp_valid 1 cycle after acceptance, status DECERR, rdata 0.
- Write to slave 2 with pslverr=1 at pready -> status SLVERR; next command is accepted only after rsp_ready.
- TIMEOUT_CYCLES_P=8; slave 0 never asserts pready -> psel drops after 8 ACCESS cycles, status TIMEOUT. Repeat with pready in the 8th cycle -> status OK.
- Assert rst in ACCESS -> next cycle psel=0, penable=0, cmd_ready=1, rsp_valid=0; a subsequent read completes OK.
